// File: rtl/bshift_pkg.sv
// Shared definitions for the pipelined barrel shifter: op encodings and
// the split of shift levels across pipeline stages.
package bshift_pkg;

  localparam logic [2:0] OP_SLL = 3'b000;
  localparam logic [2:0] OP_SRL = 3'b001;
  localparam logic [2:0] OP_SRA = 3'b010;
  localparam logic [2:0] OP_ROL = 3'b011;
  localparam logic [2:0] OP_ROR = 3'b100;

  localparam int DEFAULT_WIDTH = 32;
  localparam int SHW = $clog2(DEFAULT_WIDTH);

  // Number of shift levels (log2 of the data width).
  function automatic int shw_of(input int width);
    return $clog2(width);
  endfunction

  // Levels handled by stage s; any remainder lands in stage 0.
  function automatic int stage_levels(input int shw, input int stages, input int s);
    int base;
    int rem;
    base = shw / stages;
    rem  = shw % stages;
    return (s == 0) ? (base + rem) : base;
  endfunction

  // Index of the first level handled by stage s.
  function automatic int stage_start(input int shw, input int stages, input int s);
    int base;
    int rem;
    base = shw / stages;
    rem  = shw % stages;
    return (s == 0) ? 0 : ((base + rem) + (s - 1) * base);
  endfunction

endpackage

// File: rtl/bshift_level.sv
// One level of the left-shift core: conditionally shift or rotate by 2^K,
// tracking the last bit shifted out.
module bshift_level #(
  parameter int WIDTH = 32,
  parameter int K     = 0
) (
  input  logic [WIDTH-1:0] data_i,
  input  logic             carry_i,
  input  logic             fill_i,
  input  logic             rot_i,
  input  logic             en_i,
  output logic [WIDTH-1:0] data_o,
  output logic             carry_o
);

  localparam int S = 1 << K;

  logic [WIDTH-1:0] shifted_s;

  // Candidate result of this level: rotate wraps the top bits, shift fills.
  always_comb begin
    if (rot_i) begin
      shifted_s = {data_i[WIDTH-1-S:0], data_i[WIDTH-1:WIDTH-S]};
    end else begin
      shifted_s = {data_i[WIDTH-1-S:0], {S{fill_i}}};
    end
  end

  // For rotates the carry is the bit now at position 0; later idle levels keep it there.
  always_comb begin
    if (en_i) begin
      data_o  = shifted_s;
      carry_o = rot_i ? shifted_s[0] : data_i[WIDTH-S];
    end else begin
      data_o  = data_i;
      carry_o = carry_i;
    end
  end

endmodule

// File: rtl/pipelined_barrel_shifter.sv
// Pipelined barrel shifter with valid/ready flow control. Right shifts and
// rotates run through the left-shift core on a bit-reversed operand.
module pipelined_barrel_shifter
  import bshift_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int STAGES = 2,
  parameter int TAGW   = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [7:0]       in_shamt,
  input  logic [2:0]       in_op,
  input  logic [TAGW-1:0]  in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_carry,
  output logic             out_zero,
  output logic [TAGW-1:0]  out_tag,
  output logic             out_err
);

  localparam int LVLS = shw_of(WIDTH);

  logic stall_s;
  logic advance_s;

  logic [WIDTH-1:0] rev_in_s;
  logic [WIDTH-1:0] pre_data_s;
  logic             pre_carry_s;
  logic             pre_fill_s;
  logic             pre_rot_s;
  logic             pre_rev_s;
  logic             pre_err_s;
  logic             sat_s;
  logic [LVLS-1:0]  pre_amt_s;

  // Payload entering each stage.
  logic             sin_valid [STAGES];
  logic [WIDTH-1:0] sin_data  [STAGES];
  logic             sin_carry [STAGES];
  logic             sin_fill  [STAGES];
  logic             sin_rot   [STAGES];
  logic             sin_rev   [STAGES];
  logic             sin_err   [STAGES];
  logic [LVLS-1:0]  sin_amt   [STAGES];
  logic [TAGW-1:0]  sin_tag   [STAGES];

  logic             out_valid_q;
  logic [WIDTH-1:0] out_data_q;
  logic             out_carry_q;
  logic             out_zero_q;
  logic [TAGW-1:0]  out_tag_q;
  logic             out_err_q;

  assign stall_s   = out_valid_q & ~out_ready;
  assign advance_s = ~stall_s;
  assign in_ready  = ~stall_s;

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_carry = out_carry_q;
  assign out_zero  = out_zero_q;
  assign out_tag   = out_tag_q;
  assign out_err   = out_err_q;

  // Bit-reversed operand for the right-going ops.
  always_comb begin
    for (int i = 0; i < WIDTH; i++) begin
      rev_in_s[i] = in_data[WIDTH-1-i];
    end
  end

  // Saturated shifts collapse to the fill pattern up front so the core sees amount 0.
  always_comb begin
    pre_rev_s   = (in_op == OP_SRL) || (in_op == OP_SRA) || (in_op == OP_ROR);
    pre_rot_s   = (in_op == OP_ROL) || (in_op == OP_ROR);
    pre_fill_s  = (in_op == OP_SRA) ? in_data[WIDTH-1] : 1'b0;
    sat_s       = (in_shamt >= 8'(WIDTH));
    pre_data_s  = pre_rev_s ? rev_in_s : in_data;
    pre_amt_s   = in_shamt[LVLS-1:0];
    pre_carry_s = 1'b0;
    pre_err_s   = 1'b0;
    case (in_op)
      OP_SLL, OP_SRL, OP_SRA: begin
        if (sat_s) begin
          pre_carry_s = (in_shamt == 8'(WIDTH)) ? pre_data_s[0] : pre_fill_s;
          pre_data_s  = {WIDTH{pre_fill_s}};
          pre_amt_s   = {LVLS{1'b0}};
        end else begin
          pre_amt_s   = in_shamt[LVLS-1:0];
        end
      end
      OP_ROL, OP_ROR: begin
        pre_amt_s = in_shamt[LVLS-1:0];
      end
      default: begin
        pre_amt_s = {LVLS{1'b0}};
        pre_err_s = 1'b1;
      end
    endcase
  end

  assign sin_valid[0] = in_valid & in_ready;
  assign sin_data[0]  = pre_data_s;
  assign sin_carry[0] = pre_carry_s;
  assign sin_fill[0]  = pre_fill_s;
  assign sin_rot[0]   = pre_rot_s;
  assign sin_rev[0]   = pre_rev_s;
  assign sin_err[0]   = pre_err_s;
  assign sin_amt[0]   = pre_amt_s;
  assign sin_tag[0]   = in_tag;

  for (genvar s = 0; s < STAGES; s++) begin : g_stage
    localparam int CNT  = stage_levels(LVLS, STAGES, s);
    localparam int BASE = stage_start(LVLS, STAGES, s);

    logic [WIDTH-1:0] c_data  [CNT+1];
    logic             c_carry [CNT+1];

    assign c_data[0]  = sin_data[s];
    assign c_carry[0] = sin_carry[s];

    for (genvar j = 0; j < CNT; j++) begin : g_lvl
      bshift_level #(
        .WIDTH (WIDTH),
        .K     (BASE + j)
      ) u_level (
        .data_i  (c_data[j]),
        .carry_i (c_carry[j]),
        .fill_i  (sin_fill[s]),
        .rot_i   (sin_rot[s]),
        .en_i    (sin_amt[s][BASE+j]),
        .data_o  (c_data[j+1]),
        .carry_o (c_carry[j+1])
      );
    end

    if (s < STAGES - 1) begin : g_mid
      logic             valid_q;
      logic [WIDTH-1:0] data_q;
      logic             carry_q;
      logic             fill_q;
      logic             rot_q;
      logic             rev_q;
      logic             err_q;
      logic [LVLS-1:0]  amt_q;
      logic [TAGW-1:0]  tag_q;

      // Intermediate stage register; holds while the output is stalled.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          valid_q <= 1'b0;
          data_q  <= {WIDTH{1'b0}};
          carry_q <= 1'b0;
          fill_q  <= 1'b0;
          rot_q   <= 1'b0;
          rev_q   <= 1'b0;
          err_q   <= 1'b0;
          amt_q   <= {LVLS{1'b0}};
          tag_q   <= {TAGW{1'b0}};
        end else if (advance_s) begin
          valid_q <= sin_valid[s];
          data_q  <= c_data[CNT];
          carry_q <= c_carry[CNT];
          fill_q  <= sin_fill[s];
          rot_q   <= sin_rot[s];
          rev_q   <= sin_rev[s];
          err_q   <= sin_err[s];
          amt_q   <= sin_amt[s];
          tag_q   <= sin_tag[s];
        end
      end

      assign sin_valid[s+1] = valid_q;
      assign sin_data[s+1]  = data_q;
      assign sin_carry[s+1] = carry_q;
      assign sin_fill[s+1]  = fill_q;
      assign sin_rot[s+1]   = rot_q;
      assign sin_rev[s+1]   = rev_q;
      assign sin_err[s+1]   = err_q;
      assign sin_amt[s+1]   = amt_q;
      assign sin_tag[s+1]   = tag_q;
    end else begin : g_last
      logic [WIDTH-1:0] rev_out_s;
      logic [WIDTH-1:0] res_d;
      logic             zero_d;

      // Undo the operand reversal for right-going ops.
      always_comb begin
        for (int i = 0; i < WIDTH; i++) begin
          rev_out_s[i] = c_data[CNT][WIDTH-1-i];
        end
      end

      assign res_d  = sin_rev[s] ? rev_out_s : c_data[CNT];
      assign zero_d = (res_d == {WIDTH{1'b0}});

      // Output register; frozen while the consumer back-pressures.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          out_valid_q <= 1'b0;
          out_data_q  <= {WIDTH{1'b0}};
          out_carry_q <= 1'b0;
          out_zero_q  <= 1'b0;
          out_tag_q   <= {TAGW{1'b0}};
          out_err_q   <= 1'b0;
        end else if (advance_s) begin
          out_valid_q <= sin_valid[s];
          out_data_q  <= res_d;
          out_carry_q <= c_carry[CNT];
          out_zero_q  <= zero_d;
          out_tag_q   <= sin_tag[s];
          out_err_q   <= sin_err[s];
        end
      end
    end
  end

endmodule

// File: tb/tb_pipelined_barrel_shifter.sv
// Self-checking bench for pipelined_barrel_shifter (WIDTH=32, STAGES=2):
// directed vector table, stall stream, reset pulse and randomized traffic.
module tb_pipelined_barrel_shifter;
  import bshift_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic [7:0]  in_shamt;
  logic [2:0]  in_op;
  logic [3:0]  in_tag;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        out_carry;
  logic        out_zero;
  logic [3:0]  out_tag;
  logic        out_err;

  always #5 clk = ~clk;

  pipelined_barrel_shifter #(.WIDTH(32), .STAGES(2), .TAGW(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_shamt(in_shamt), .in_op(in_op), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_carry(out_carry), .out_zero(out_zero), .out_tag(out_tag), .out_err(out_err)
  );

  typedef struct {
    logic [2:0]  op;
    logic [31:0] data;
    logic [7:0]  shamt;
    logic [31:0] exp_data;
    logic        exp_carry;
    logic        exp_zero;
    logic        exp_err;
  } vec_t;

  typedef struct {
    logic [31:0] data;
    logic        carry;
    logic        zero;
    logic        err;
    logic [3:0]  tag;
  } res_t;

  res_t exp_q[$];
  int   n_checks  = 0;
  int   n_fail    = 0;
  int   out_count = 0;
  bit   mon_en    = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: the shift rules written directly as arithmetic on the operand.
  function automatic res_t model(input logic [2:0] op, input logic [31:0] d,
                                 input logic [7:0] shamt, input logic [3:0] tag);
    res_t r;
    int n;
    int m;
    n = int'(shamt);
    m = n % 32;
    r.tag = tag;
    r.err = 1'b0;
    r.carry = 1'b0;
    r.data = d;
    case (op)
      3'd0: begin
        if (n == 0) begin r.data = d; r.carry = 1'b0; end
        else if (n < 32) begin r.data = d << n; r.carry = d[32-n]; end
        else if (n == 32) begin r.data = 32'd0; r.carry = d[0]; end
        else begin r.data = 32'd0; r.carry = 1'b0; end
      end
      3'd1: begin
        if (n == 0) begin r.data = d; r.carry = 1'b0; end
        else if (n < 32) begin r.data = d >> n; r.carry = d[n-1]; end
        else if (n == 32) begin r.data = 32'd0; r.carry = d[31]; end
        else begin r.data = 32'd0; r.carry = 1'b0; end
      end
      3'd2: begin
        if (n == 0) begin r.data = d; r.carry = 1'b0; end
        else if (n < 32) begin r.data = 32'($signed(d) >>> n); r.carry = d[n-1]; end
        else begin r.data = {32{d[31]}}; r.carry = d[31]; end
      end
      3'd3: begin
        if (m == 0) begin r.data = d; r.carry = 1'b0; end
        else begin r.data = (d << m) | (d >> (32 - m)); r.carry = r.data[0]; end
      end
      3'd4: begin
        if (m == 0) begin r.data = d; r.carry = 1'b0; end
        else begin r.data = (d >> m) | (d << (32 - m)); r.carry = r.data[31]; end
      end
      default: begin r.data = d; r.carry = 1'b0; r.err = 1'b1; end
    endcase
    r.zero = (r.data == 32'd0);
    return r;
  endfunction

  // Scoreboard monitor: order, payload, stall stability and in_ready.
  initial begin
    res_t       e;
    res_t       got;
    logic [31:0] snap_data;
    logic        snap_carry, snap_zero, snap_err;
    logic [3:0]  snap_tag;
    bit          prev_stall;
    prev_stall = 1'b0;
    snap_data = 32'd0; snap_carry = 1'b0; snap_zero = 1'b0; snap_err = 1'b0; snap_tag = 4'd0;
    forever begin
      @(negedge clk);
      if (mon_en && rst_n) begin
        if (prev_stall && out_valid) begin
          check("stall hold data", out_data, snap_data);
          check("stall hold flags", {out_carry, out_zero, out_err, out_tag},
                {snap_carry, snap_zero, snap_err, snap_tag});
        end
        check("in_ready", in_ready, !(out_valid && !out_ready));
        if (out_valid && out_ready) begin
          out_count++;
          got.data = out_data; got.carry = out_carry; got.zero = out_zero;
          got.err = out_err; got.tag = out_tag;
          if (exp_q.size() == 0) begin
            check("unexpected result", 1'b1, 1'b0);
          end else begin
            e = exp_q.pop_front();
            check("mon tag", got.tag, e.tag);
            check("mon data", got.data, e.data);
            check("mon flags", {got.carry, got.zero, got.err}, {e.carry, e.zero, e.err});
          end
        end
        if (in_valid && in_ready) exp_q.push_back(model(in_op, in_data, in_shamt, in_tag));
        prev_stall = out_valid && !out_ready;
        snap_data = out_data; snap_carry = out_carry; snap_zero = out_zero;
        snap_err = out_err; snap_tag = out_tag;
      end else begin
        prev_stall = 1'b0;
      end
    end
  end

  task automatic apply_one(input vec_t v, input logic [3:0] tag, input string nm);
    int lat;
    @(posedge clk); #1;
    in_valid = 1'b1; in_op = v.op; in_data = v.data; in_shamt = v.shamt;
    in_tag = tag; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 10) begin
      @(posedge clk); #1;
      lat++;
    end
    check({nm, " latency"}, 64'(lat), 64'd2);
    check({nm, " data"}, out_data, v.exp_data);
    check({nm, " carry"}, out_carry, v.exp_carry);
    check({nm, " zero"}, out_zero, v.exp_zero);
    check({nm, " err"}, out_err, v.exp_err);
    check({nm, " tag"}, out_tag, tag);
  endtask

  vec_t vecs [15];

  initial begin
    int i;
    int cyc;
    int k;
    vecs[0]  = '{3'd0, 32'h0000_0001, 8'd31, 32'h8000_0000, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{3'd2, 32'h8000_00F0, 8'd4,  32'hF800_000F, 1'b0, 1'b0, 1'b0};
    vecs[2]  = '{3'd2, 32'h8000_00F0, 8'd40, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0};
    vecs[3]  = '{3'd4, 32'h0000_0001, 8'd33, 32'h8000_0000, 1'b1, 1'b0, 1'b0};
    vecs[4]  = '{3'd3, 32'h8000_0000, 8'd32, 32'h8000_0000, 1'b0, 1'b0, 1'b0};
    vecs[5]  = '{3'd1, 32'h0000_0003, 8'd2,  32'h0000_0000, 1'b1, 1'b1, 1'b0};
    vecs[6]  = '{3'd7, 32'h1234_5678, 8'd5,  32'h1234_5678, 1'b0, 1'b0, 1'b1};
    vecs[7]  = '{3'd0, 32'h0000_0001, 8'd32, 32'h0000_0000, 1'b1, 1'b1, 1'b0};
    vecs[8]  = '{3'd1, 32'h8000_0000, 8'd32, 32'h0000_0000, 1'b1, 1'b1, 1'b0};
    vecs[9]  = '{3'd0, 32'hDEAD_BEEF, 8'd0,  32'hDEAD_BEEF, 1'b0, 1'b0, 1'b0};
    vecs[10] = '{3'd1, 32'hFFFF_FFFF, 8'd33, 32'h0000_0000, 1'b0, 1'b1, 1'b0};
    vecs[11] = '{3'd3, 32'h8000_0001, 8'd1,  32'h0000_0003, 1'b1, 1'b0, 1'b0};
    vecs[12] = '{3'd4, 32'h0000_0002, 8'd1,  32'h0000_0001, 1'b0, 1'b0, 1'b0};
    vecs[13] = '{3'd5, 32'h0000_0000, 8'd3,  32'h0000_0000, 1'b0, 1'b1, 1'b1};
    vecs[14] = '{3'd0, 32'hFFFF_FFFF, 8'd4,  32'hFFFF_FFF0, 1'b1, 1'b0, 1'b0};

    rst_n = 1'b0; in_valid = 1'b0; in_data = 32'd0; in_shamt = 8'd0;
    in_op = 3'd0; in_tag = 4'd0; out_ready = 1'b1;
    #12;
    check("reset out_valid", out_valid, 1'b0);
    check("reset in_ready", in_ready, 1'b1);
    check("reset outputs", {out_data, out_carry, out_zero, out_tag, out_err}, 39'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int v = 0; v < 15; v++) begin
      apply_one(vecs[v], 4'(v), $sformatf("vec%0d", v));
    end

    // Back-to-back stream with a three-cycle output stall.
    @(posedge clk); #1;
    mon_en = 1'b1; out_count = 0; i = 0; cyc = 0;
    while (i < 8 && cyc < 100) begin
      @(posedge clk); #1;
      out_ready = !(cyc >= 3 && cyc <= 5);
      in_valid = 1'b1; in_op = 3'(i % 5); in_data = $urandom;
      in_shamt = 8'(i * 5); in_tag = 4'(i);
      @(negedge clk);
      if (cyc == 3) check("stall start in_ready", {out_valid, in_ready}, 2'b10);
      if (in_ready) i++;
      cyc++;
    end
    @(posedge clk); #1;
    in_valid = 1'b0; out_ready = 1'b1;
    k = 0;
    while (exp_q.size() != 0 && k < 50) begin
      @(posedge clk);
      k++;
    end
    @(negedge clk);
    check("stream result count", 64'(out_count), 64'd8);
    check("stream queue empty", 64'(exp_q.size()), 64'd0);
    mon_en = 1'b0;

    // Reset pulse with two operations in flight.
    @(posedge clk); #1;
    out_ready = 1'b0; in_valid = 1'b1; in_op = 3'd0; in_data = 32'h0000_00FF;
    in_shamt = 8'd1; in_tag = 4'hA;
    @(posedge clk); #1;
    in_tag = 4'hB;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("inflight out_valid", out_valid, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async reset out_valid", out_valid, 1'b0);
    check("async reset in_ready", in_ready, 1'b1);
    @(posedge clk); #4;
    rst_n = 1'b1;
    out_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      check("no stale result", out_valid, 1'b0);
    end
    apply_one(vecs[1], 4'h3, "post reset");

    // Randomized traffic against the reference model.
    @(posedge clk); #1;
    mon_en = 1'b1;
    for (int c = 0; c < 400; c++) begin
      @(posedge clk); #1;
      in_valid = ($urandom_range(0, 3) != 0);
      in_op = 3'($urandom_range(0, 7));
      case ($urandom_range(0, 3))
        0: in_data = 32'h8000_0000 | 32'($urandom_range(0, 255));
        1: in_data = 32'($urandom_range(0, 15));
        default: in_data = $urandom;
      endcase
      in_shamt = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(0, 40)) : 8'($urandom_range(0, 255));
      in_tag = 4'($urandom_range(0, 15));
      out_ready = ($urandom_range(0, 3) != 0);
    end
    @(posedge clk); #1;
    in_valid = 1'b0; out_ready = 1'b1;
    k = 0;
    while (exp_q.size() != 0 && k < 50) begin
      @(posedge clk);
      k++;
    end
    @(negedge clk);
    check("random drain", 64'(exp_q.size()), 64'd0);
    mon_en = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
